// File: rtl/debug_cmd_pkg.sv
// Shared definitions for the CPU debug-slave command dispatcher: default widths,
// FSM state encodings and the layout of one queued command.
package debug_cmd_pkg;

  localparam int DEF_IR_WIDTH   = 2;
  localparam int DEF_DR_WIDTH   = 38;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_NUM_CHAN   = 2 ** DEF_IR_WIDTH;
  localparam int DEF_LEVEL_W    = $clog2(DEF_FIFO_DEPTH + 1);

  // The ack timeout is at most 65535 cycles, so a 16-bit counter always suffices.
  localparam int TIMER_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_DISPATCH = 2'd1;
  localparam state_t ST_WAIT_ACK = 2'd2;

  // One captured command in the default configuration: channel select above data.
  typedef struct packed {
    logic [DEF_IR_WIDTH-1:0] ir;
    logic [DEF_DR_WIDTH-1:0] data;
  } cmd_t;

endpackage

// File: rtl/debug_cmd_fifo.sv
// Small synchronous command queue. A push while full is accepted only when a pop
// frees a slot in the same cycle; otherwise it is silently refused.
module debug_cmd_fifo
  import debug_cmd_pkg::*;
#(
  parameter int WIDTH = DEF_IR_WIDTH + DEF_DR_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage has no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/debug_cmd_dispatch.sv
// Sysclk-side capture of virtual-JTAG update-DR commands, queued and dispatched as
// one-cycle take_action / take_no_action pulses, with optional per-channel ack wait.
module debug_cmd_dispatch
  import debug_cmd_pkg::*;
#(
  parameter int                       IR_WIDTH    = DEF_IR_WIDTH,
  parameter int                       DR_WIDTH    = DEF_DR_WIDTH,
  parameter int                       ACT_BIT     = 37,
  parameter logic [(2**IR_WIDTH)-1:0] ACK_MASK    = 4'b0011,
  parameter int                       FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int                       SYNC_STAGES = 2,
  parameter int                       TIMEOUT_CYC = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [IR_WIDTH-1:0]             ir_in,
  input  logic [DR_WIDTH-1:0]             sr,
  input  logic                            vs_udr,
  input  logic [(2**IR_WIDTH)-1:0]        chan_ack,
  input  logic                            err_clear,
  output logic [DR_WIDTH-1:0]             jdo,
  output logic [(2**IR_WIDTH)-1:0]        take_action,
  output logic [(2**IR_WIDTH)-1:0]        take_no_action,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overflow,
  output logic                            timeout_err
);

  localparam int NUM_CHAN = 2 ** IR_WIDTH;
  localparam int CMD_W    = IR_WIDTH + DR_WIDTH;
  localparam int ARM_W    = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   udr_prev;
  logic                   arm;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   upd_rise;

  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CMD_W-1:0]       fifo_rdata;

  state_t                 state;
  logic [IR_WIDTH-1:0]    chan;
  logic [TIMER_WIDTH-1:0] wait_cnt;
  logic                   timer_done;
  logic                   ack_seen;
  logic                   timeout_hit;
  logic                   drop_cmd;
  logic [NUM_CHAN-1:0]    chan_sel;

  // Bring the asynchronous update level into the clk domain and keep its previous value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      udr_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], vs_udr};
      udr_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // Hold off edge detection until the synchroniser has flushed, so a level already high at reset release is not a command.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt <= '0;
      arm     <= 1'b0;
    end else if (!arm) begin
      if (arm_cnt == ARM_W'(SYNC_STAGES)) arm <= 1'b1;
      else arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign upd_rise    = arm && sync_q[SYNC_STAGES-1] && !udr_prev;
  assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
  assign drop_cmd    = upd_rise && fifo_full && !fifo_pop;
  assign timer_done  = (wait_cnt == TIMER_WIDTH'(TIMEOUT_CYC - 1));
  assign ack_seen    = (state == ST_WAIT_ACK) && chan_ack[chan];
  assign timeout_hit = (state == ST_WAIT_ACK) && !chan_ack[chan] && timer_done;
  assign busy        = (state != ST_IDLE) || !fifo_empty;

  debug_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (upd_rise),
    .pop   (fifo_pop),
    .wdata ({ir_in, sr}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Dispatch sequencer: pop into jdo, pulse for one cycle, then optionally wait for the channel ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      jdo      <= '0;
      chan     <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            jdo   <= fifo_rdata[DR_WIDTH-1:0];
            chan  <= fifo_rdata[CMD_W-1:DR_WIDTH];
            state <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          wait_cnt <= '0;
          if (jdo[ACT_BIT] && ACK_MASK[chan]) state <= ST_WAIT_ACK;
          else state <= ST_IDLE;
        end
        ST_WAIT_ACK: begin
          if (ack_seen || timer_done) state <= ST_IDLE;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a fresh error in the same cycle as err_clear stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop_cmd) overflow <= 1'b1;
      else if (err_clear) overflow <= 1'b0;
      if (timeout_hit) timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;
    end
  end

  // One-hot pulse on the dispatched channel, split by the action bit of jdo.
  always_comb begin
    chan_sel       = '0;
    chan_sel[chan] = 1'b1;
    take_action    = '0;
    take_no_action = '0;
    if (state == ST_DISPATCH) begin
      if (jdo[ACT_BIT]) take_action = chan_sel;
      else take_no_action = chan_sel;
    end
  end

endmodule

// File: tb/tb_debug_cmd_dispatch.sv
// Self-checking bench for debug_cmd_dispatch: scenario tasks plus an in-order
// scoreboard of expected dispatches that every take_* pulse is checked against.
module tb_debug_cmd_dispatch;
  import debug_cmd_pkg::*;

  localparam int         IR_WIDTH    = 2;
  localparam int         DR_WIDTH    = 38;
  localparam int         ACT_BIT     = 37;
  localparam logic [3:0] ACK_MASK    = 4'b0011;
  localparam int         FIFO_DEPTH  = 4;
  localparam int         SYNC_STAGES = 2;
  localparam int         TIMEOUT_CYC = 255;
  localparam int         LATENCY     = SYNC_STAGES + 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [IR_WIDTH-1:0] ir_in = '0;
  logic [DR_WIDTH-1:0] sr = '0;
  logic                vs_udr = 1'b0;
  logic [3:0]          chan_ack = '0;
  logic                err_clear = 1'b0;
  logic [DR_WIDTH-1:0] jdo;
  logic [3:0]          take_action;
  logic [3:0]          take_no_action;
  logic                busy;
  logic [2:0]          fifo_level;
  logic                overflow;
  logic                timeout_err;

  int   checks = 0;
  int   passed = 0;
  int   pulse_cnt = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  cmd_t exp_q[$];
  int   pulse_cycles[$];

  debug_cmd_dispatch #(
    .IR_WIDTH    (IR_WIDTH),
    .DR_WIDTH    (DR_WIDTH),
    .ACT_BIT     (ACT_BIT),
    .ACK_MASK    (ACK_MASK),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ir_in          (ir_in),
    .sr             (sr),
    .vs_udr         (vs_udr),
    .chan_ack       (chan_ack),
    .err_clear      (err_clear),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .busy           (busy),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .timeout_err    (timeout_err)
  );

  // Free-running clock and cycle counter used to time pulse spacing.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must match the oldest command the model expects, in order.
  always @(negedge clk) begin
    cmd_t       e;
    logic [3:0] exp_act;
    logic [3:0] exp_noact;
    if (mon_en && ((take_action | take_no_action) != '0)) begin
      pulse_cnt++;
      pulse_cycles.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_pulse: act=%b noact=%b, required none", take_action, take_no_action);
      end else begin
        e = exp_q.pop_front();
        exp_act   = '0;
        exp_noact = '0;
        if (e.data[ACT_BIT]) exp_act[e.ir] = 1'b1;
        else exp_noact[e.ir] = 1'b1;
        if ({take_action, take_no_action} !== {exp_act, exp_noact})
          $display("[TB] FAIL pulse_chan: act=%b noact=%b, required act=%b noact=%b", take_action, take_no_action, exp_act, exp_noact);
        else passed++;
        checks++;
        if (jdo !== e.data) $display("[TB] FAIL pulse_jdo: got %h, required %h", jdo, e.data);
        else passed++;
      end
    end
  end

  function automatic logic [DR_WIDTH-1:0] rand_data(input bit act);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[ACT_BIT] = act;
    return r[DR_WIDTH-1:0];
  endfunction

  function automatic bit needs_ack(input logic [1:0] ir, input logic [DR_WIDTH-1:0] d);
    return ACK_MASK[ir] && d[ACT_BIT];
  endfunction

  task automatic start_cmd(input logic [1:0] ir, input logic [DR_WIDTH-1:0] data, input bit accept);
    cmd_t c;
    @(negedge clk);
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    if (accept) begin
      c.ir   = ir;
      c.data = data;
      exp_q.push_back(c);
    end
  endtask

  task automatic wait_pulse(input int max_cyc, output int waited);
    waited = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if ((take_action | take_no_action) != '0) begin
        waited = i;
        break;
      end
    end
    if (waited == 0) begin
      checks++;
      $display("[TB] FAIL pulse_wait: no take_* pulse within %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (jdo !== '0) $display("[TB] FAIL reset_jdo: got %h, required 0", jdo);
    else passed++;
    checks++;
    if ({take_action, take_no_action} !== 8'h00) $display("[TB] FAIL reset_take: got %b, required 0", {take_action, take_no_action});
    else passed++;
    checks++;
    if ({busy, fifo_level} !== 4'h0) $display("[TB] FAIL reset_busy_level: got %b, required 0", {busy, fifo_level});
    else passed++;
    checks++;
    if ({overflow, timeout_err} !== 2'b00) $display("[TB] FAIL reset_sticky: got %b, required 00", {overflow, timeout_err});
    else passed++;
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_action_no_ack();
    logic [DR_WIDTH-1:0] d;
    int w;
    d = 38'h20000000AB;
    start_cmd(2'd2, d, 1'b1);
    wait_pulse(10, w);
    vs_udr = 1'b0;
    checks++;
    if (w !== LATENCY) $display("[TB] FAIL latency: got %0d, required %0d", w, LATENCY);
    else passed++;
    checks++;
    if (take_action !== 4'b0100) $display("[TB] FAIL act_ch2: got %b, required 0100", take_action);
    else passed++;
    @(negedge clk);
    checks++;
    if ({busy, take_action} !== 5'b0) $display("[TB] FAIL act_ch2_done: busy/act=%b, required 0", {busy, take_action});
    else passed++;
    repeat (5) @(negedge clk);
    checks++;
    if (jdo !== d) $display("[TB] FAIL jdo_hold: got %h, required %h", jdo, d);
    else passed++;
  endtask

  task automatic test_ack_wait();
    int w;
    start_cmd(2'd0, rand_data(1'b1), 1'b1);
    wait_pulse(10, w);
    vs_udr = 1'b0;
    repeat (9) @(negedge clk);
    chan_ack = 4'b0001;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL ack_wait_busy: got %b, required 1", busy);
    else passed++;
    @(negedge clk);
    chan_ack = 4'b0000;
    checks++;
    if ({busy, timeout_err} !== 2'b00) $display("[TB] FAIL ack_done: busy/terr=%b, required 00", {busy, timeout_err});
    else passed++;
    repeat (3) @(negedge clk);
    start_cmd(2'd0, rand_data(1'b1), 1'b1);
    wait_pulse(10, w);
    vs_udr = 1'b0;
    repeat (TIMEOUT_CYC) @(negedge clk);
    checks++;
    if ({busy, timeout_err} !== 2'b10) $display("[TB] FAIL timeout_early: busy/terr=%b, required 10", {busy, timeout_err});
    else passed++;
    @(negedge clk);
    checks++;
    if ({busy, timeout_err} !== 2'b01) $display("[TB] FAIL timeout_set: busy/terr=%b, required 01", {busy, timeout_err});
    else passed++;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) $display("[TB] FAIL timeout_clear: got %b, required 0", timeout_err);
    else passed++;
  endtask

  task automatic test_no_action();
    int w;
    start_cmd(2'd1, rand_data(1'b0), 1'b1);
    wait_pulse(10, w);
    vs_udr = 1'b0;
    checks++;
    if ({take_action, take_no_action} !== 8'b0000_0010) $display("[TB] FAIL noact_ch1: got %b, required 00000010", {take_action, take_no_action});
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL noact_no_wait: busy=%b, required 0", busy);
    else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    int w;
    int base;
    int k;
    base = pulse_cnt;
    start_cmd(2'd0, rand_data(1'b1), 1'b1);
    wait_pulse(10, w);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start_cmd(2'($urandom_range(2, 3)), rand_data(1'($urandom_range(0, 1))), i < FIFO_DEPTH);
      repeat (3) @(negedge clk);
      vs_udr = 1'b0;
      repeat (3) @(negedge clk);
    end
    checks++;
    if (fifo_level !== 3'd4) $display("[TB] FAIL ovf_level: got %0d, required 4", fifo_level);
    else passed++;
    checks++;
    if ({busy, overflow, timeout_err} !== 3'b110) $display("[TB] FAIL ovf_flags: busy/ovf/terr=%b, required 110", {busy, overflow, timeout_err});
    else passed++;
    pulse_cycles.delete();
    chan_ack = 4'b0001;
    @(negedge clk);
    chan_ack = 4'b0000;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL drain_idle: busy=%b after %0d cycles, required 0", busy, k);
    else passed++;
    checks++;
    if ((pulse_cnt - base) !== 5 || exp_q.size() !== 0)
      $display("[TB] FAIL drain_count: pulses=%0d left=%0d, required 5 and 0", pulse_cnt - base, exp_q.size());
    else passed++;
    for (int j = 1; j < pulse_cycles.size(); j++) begin
      checks++;
      if (pulse_cycles[j] - pulse_cycles[j-1] !== 2)
        $display("[TB] FAIL drain_spacing: got %0d cycles, required 2", pulse_cycles[j] - pulse_cycles[j-1]);
      else passed++;
    end
    checks++;
    if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b, required 1", overflow);
    else passed++;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++;
    if (overflow !== 1'b0) $display("[TB] FAIL ovf_clear: got %b, required 0", overflow);
    else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w;
    int base;
    reset  = 1'b1;
    vs_udr = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base  = pulse_cnt;
    repeat (12) @(negedge clk);
    checks++;
    if ({busy, fifo_level} !== 4'h0 || pulse_cnt !== base)
      $display("[TB] FAIL udr_at_release: busy/level=%b pulses=%0d, required 0 and 0", {busy, fifo_level}, pulse_cnt - base);
    else passed++;
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    start_cmd(2'd0, rand_data(1'b1), 1'b1);
    wait_pulse(10, w);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start_cmd(2'($urandom_range(0, 3)), rand_data(1'($urandom_range(0, 1))), 1'b1);
      repeat (3) @(negedge clk);
      vs_udr = 1'b0;
      repeat (3) @(negedge clk);
    end
    checks++;
    if ({busy, fifo_level} !== 4'b1011) $display("[TB] FAIL mid_level: busy/level=%b, required 1011", {busy, fifo_level});
    else passed++;
    reset = 1'b1;
    exp_q.delete();
    base = pulse_cnt;
    @(negedge clk);
    checks++;
    if ({jdo, take_action, take_no_action, busy, fifo_level, overflow, timeout_err} !== '0)
      $display("[TB] FAIL mid_reset_outputs: jdo=%h busy=%b level=%0d, required all 0", jdo, busy, fifo_level);
    else passed++;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (pulse_cnt !== base || busy !== 1'b0) $display("[TB] FAIL mid_reset_quiet: pulses=%0d busy=%b, required 0 and 0", pulse_cnt - base, busy);
    else passed++;
  endtask

  task automatic test_ack_expiry();
    int w;
    start_cmd(2'd0, rand_data(1'b1), 1'b1);
    wait_pulse(10, w);
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);
    chan_ack = 4'b0010;
    @(negedge clk);
    chan_ack = 4'b0000;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL other_ack_ignored: busy=%b, required 1", busy);
    else passed++;
    repeat (TIMEOUT_CYC - 6) @(negedge clk);
    chan_ack = 4'b0001;
    checks++;
    if ({busy, timeout_err} !== 2'b10) $display("[TB] FAIL expiry_pre: busy/terr=%b, required 10", {busy, timeout_err});
    else passed++;
    @(negedge clk);
    chan_ack = 4'b0000;
    checks++;
    if ({busy, timeout_err} !== 2'b00) $display("[TB] FAIL expiry_ack_wins: busy/terr=%b, required 00", {busy, timeout_err});
    else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0]          ir;
    logic [DR_WIDTH-1:0] d;
    int                  w;
    for (int n = 0; n < 10; n++) begin
      ir = 2'($urandom_range(0, 3));
      d  = rand_data(1'($urandom_range(0, 1)));
      start_cmd(ir, d, 1'b1);
      wait_pulse(10, w);
      vs_udr = 1'b0;
      checks++;
      if (w !== LATENCY) $display("[TB] FAIL rand_latency: got %0d, required %0d", w, LATENCY);
      else passed++;
      if (needs_ack(ir, d)) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL rand_wait_busy: busy=%b, required 1", busy);
        else passed++;
        chan_ack = 4'b0001 << ir;
        @(negedge clk);
        chan_ack = 4'b0000;
      end else begin
        @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0 || jdo !== d) $display("[TB] FAIL rand_done: busy=%b jdo=%h, required 0 and %h", busy, jdo, d);
      else passed++;
      repeat (3) @(negedge clk);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_action_no_ack();
    test_ack_wait();
    test_no_action();
    test_overflow();
    test_reset_mid();
    test_ack_expiry();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Watchdog so a stuck design cannot hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
